pc_sequencer: RTL
=================

# pc_sequencer

Control FSM that sequences the 8-bit program counter register: it computes the value the PC loads every clock, covering hold, increment, jump, conditional branch, call and return. It also owns a small return-address stack. It sits between the instruction-fetch interface and the PC register. Its `pc_next` drives the PC load input, and the PC output feeds back as `pc_cur`. The PC register loads on every clock, so the sequencer holds the PC by driving `pc_next = pc_cur`.

## Interface
Parameters:
- `PC_W`, 8: program counter width.
- `STACK_DEPTH`, 4: return-address stack entries; must be a power of two, at least 2.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `RST`, input, 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `pc_cur`, input, `PC_W`: current PC register value.
- `pc_next`, output, `PC_W`: value the PC register loads at the next edge.
- `fetch_req`, output, 1: request an instruction at `pc_cur`.
- `instr_valid`, input, 1: fetch interface has `op`/`target` ready; meaningful only while `fetch_req` is 1.
- `op`, input, 3: instruction class.
  - 000 SEQ, 001 JMP, 010 BZ, 011 CALL, 100 RET, 101 HALT.
  - 110 and 111 are treated as SEQ.
- `target`, input, `PC_W`: jump, branch or call destination.
- `zero_flag`, input, 1: ALU zero flag, sampled together with `op`.
- `halted`, output, 1: FSM is in HALT.
- `stack_err`, output, 1: sticky flag, set by stack overflow or underflow.
- `sp_depth`, output, $clog2(`STACK_DEPTH`)+1: number of valid stack entries.

## Operation
States are FETCH, EXEC and HALT.
- **FETCH:**
  - `fetch_req`=1 and `pc_next`=`pc_cur`.
  - If `instr_valid`=1: latch `op`, `target` and `zero_flag` into internal registers, then go to EXEC. Otherwise stay in FETCH.
- **EXEC:** `fetch_req`=0. `pc_next` is computed from the latched fields, using inc = `pc_cur`+1 modulo 2^`PC_W` (8'hFF wraps to 8'h00):
  - SEQ: inc.
  - JMP: target.
  - BZ: target if the latched zero flag is 1, else inc.
  - CALL: push inc, then `pc_next`=target.
  - RET: pop, then `pc_next`=popped value.
  - HALT: `pc_next`=`pc_cur`; next state is HALT.
  - Every other case: next state is FETCH.
- **Stack errors:**
  - CALL with `sp_depth`=`STACK_DEPTH` (overflow) or RET with `sp_depth`=0 (underflow): no push or pop, `pc_next`=`pc_cur`.
  - `stack_err` is set and the next state is HALT.
- **HALT:** `pc_next`=`pc_cur`, `fetch_req`=0, `halted`=1. Only reset exits HALT.
- **Stack behaviour:**
  - LIFO; push writes at index `sp_depth` and then increments it.
  - Pop reads the entry at `sp_depth`-1 and then decrements.
  - Entry contents are not reset; only the pointer is.
- **Reset** (RST=0 at an edge):
  - State goes to FETCH, `sp_depth`=0, `stack_err`=0, latched instruction cleared to SEQ.
  - While RST is low, outputs are forced: `fetch_req`=0, `pc_next`=`pc_cur`, `halted`=0.
  - An instruction in flight at reset is discarded; no push or pop occurs in that cycle.

## Timing
- All outputs are decoded combinationally from registered state plus `pc_cur`; there is no combinational path from `instr_valid`, `op` or `target` to any output.
- Handshake:
  - A transfer happens at an edge where `fetch_req`=1 and `instr_valid`=1.
  - `instr_valid` may stay low for any number of cycles; the PC holds throughout.
- Latency, with the transfer at edge E0:
  - EXEC occupies the cycle E0..E1.
  - The PC holds the new value after E1.
  - `fetch_req` is 1 again in the cycle after E1.
  - Minimum of 2 cycles per instruction.
- `stack_err` and `halted` assert in the cycle after the faulting EXEC edge and remain set until reset.
- `sp_depth` changes at the EXEC→FETCH edge.

## Structure
- Shared package `pc_seq_pkg` holds:
  - the opcode localparams (OP_SEQ … OP_HALT);
  - the state enum encoding (FETCH=2'd0, EXEC=2'd1, HALT=2'd2);
  - the default `PC_W`.
- One sub-module, `ras_stack`:
  - parameterised by `PC_W` and `STACK_DEPTH`;
  - ports: push, pop, din, dout, depth, full, empty;
  - same clk/RST convention.
- The FSM and next-PC mux live in `pc_sequencer`.

## Test plan
- **Reset, then stall:**
  - Stimulus: RST low for 2 cycles, then high; `instr_valid` held low for 5 cycles; `pc_cur`=8'h00.
  - Required: `fetch_req`=1 and `pc_next`=8'h00 for all 5 cycles; `sp_depth`=0.
- **SEQ with wrap:**
  - Stimulus: `pc_cur`=8'hFE, then 8'hFF, feeding SEQ each time.
  - Required: EXEC `pc_next`=8'hFF, then 8'h00; exactly 2 cycles per instruction.
- **BZ:**
  - Stimulus: `pc_cur`=8'h10, `target`=8'h40.
  - Required: with zero=1, EXEC `pc_next`=8'h40; with zero=0, EXEC `pc_next`=8'h11.
- **CALL/RET:**
  - Stimulus: CALL 8'h80 at `pc_cur`=8'h05, then RET at 8'h80.
  - Required: CALL gives `pc_next`=8'h80 and `sp_depth`=1; RET gives `pc_next`=8'h06 and `sp_depth`=0.
- **Overflow, then HALT:**
  - Stimulus: 5 consecutive CALLs with `STACK_DEPTH`=4.
  - Required: the 5th CALL gives `pc_next`=`pc_cur`, `stack_err`=1, `halted`=1, `sp_depth`=4; `fetch_req` stays 0 afterwards.
- **Reset mid-EXEC:**
  - Stimulus: RST low during a CALL's EXEC cycle.
  - Required: no push (`sp_depth`=0), state FETCH after release, `stack_err`=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: opcodes, FSM state
// encoding and default widths.
package pc_seq_pkg;

    localparam int unsigned PC_W_DEF = 8;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned ST_W     = 2;

    // Instruction classes; 3'b110 and 3'b111 decode as SEQ.
    localparam logic [OP_W-1:0] OP_SEQ  = 3'd0;
    localparam logic [OP_W-1:0] OP_JMP  = 3'd1;
    localparam logic [OP_W-1:0] OP_BZ   = 3'd2;
    localparam logic [OP_W-1:0] OP_CALL = 3'd3;
    localparam logic [OP_W-1:0] OP_RET  = 3'd4;
    localparam logic [OP_W-1:0] OP_HALT = 3'd5;

    // FSM state encoding.
    localparam logic [ST_W-1:0] ST_FETCH = 2'd0;
    localparam logic [ST_W-1:0] ST_EXEC  = 2'd1;
    localparam logic [ST_W-1:0] ST_HALT  = 2'd2;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack (LIFO). Only the pointer is reset; entries are not.
// Ports: clk, RST (sync, active-low), push/din write at index depth,
// pop removes entry depth-1, dout shows the top entry, depth/full/empty status.
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEF,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         RST,
    input  logic                         push,
    input  logic                         pop,
    input  logic [PC_W-1:0]              din,
    output logic [PC_W-1:0]              dout,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = $clog2(STACK_DEPTH);
    localparam int unsigned DW = AW + 1;

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [DW-1:0]   sp;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    // Power-of-two depth means the truncated index always lands in range.
    assign wr_idx = AW'(sp);
    assign rd_idx = AW'(sp - DW'(1));

    assign dout  = mem[rd_idx];
    assign depth = sp;
    assign full  = (sp == DW'(STACK_DEPTH));
    assign empty = (sp == '0);

    // Stack pointer; push and pop are ignored at the full/empty limits.
    always_ff @(posedge clk) begin
        if (!RST) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + DW'(1);
        end else if (pop && !empty) begin
            sp <= sp - DW'(1);
        end
    end

    // Entry storage, deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (RST && push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// FETCH/EXEC/HALT control FSM producing the PC load value each clock.
// Ports: clk, RST (sync, active-low), pc_cur (PC feedback), pc_next (PC load),
// fetch_req/instr_valid handshake with op/target/zero_flag, halted,
// stack_err (sticky), sp_depth (return-stack occupancy).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEF,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         RST,
    input  logic [PC_W-1:0]              pc_cur,
    output logic [PC_W-1:0]              pc_next,
    output logic                         fetch_req,
    input  logic                         instr_valid,
    input  logic [OP_W-1:0]              op,
    input  logic [PC_W-1:0]              target,
    input  logic                         zero_flag,
    output logic                         halted,
    output logic                         stack_err,
    output logic [$clog2(STACK_DEPTH):0] sp_depth
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;
    logic [OP_W-1:0] lat_op;
    logic [PC_W-1:0] lat_target;
    logic            lat_zero;

    logic            load;
    logic            push;
    logic            pop;
    logic            err_set;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] ras_dout;
    logic            ras_full;
    logic            ras_empty;

    assign pc_inc = pc_cur + PC_W'(1);

    ras_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk   (clk),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (ras_dout),
        .depth (sp_depth),
        .full  (ras_full),
        .empty (ras_empty)
    );

    // State, latched instruction and sticky error flag.
    always_ff @(posedge clk) begin
        if (!RST) begin
            state      <= ST_FETCH;
            lat_op     <= OP_SEQ;
            lat_target <= '0;
            lat_zero   <= 1'b0;
            stack_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                lat_op     <= op;
                lat_target <= target;
                lat_zero   <= zero_flag;
            end
            if (err_set) begin
                stack_err <= 1'b1;
            end
        end
    end

    // Next-state, next-PC and stack control decode.
    always_comb begin
        state_nxt = state;
        pc_next   = pc_cur;
        fetch_req = 1'b0;
        halted    = 1'b0;
        load      = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;

        case (state)
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                case (lat_op)
                    OP_JMP:  pc_next = lat_target;
                    OP_BZ:   pc_next = lat_zero ? lat_target : pc_inc;
                    OP_CALL: begin
                        if (ras_full) begin
                            err_set   = 1'b1;
                            state_nxt = ST_HALT;
                        end else begin
                            push    = 1'b1;
                            pc_next = lat_target;
                        end
                    end
                    OP_RET: begin
                        if (ras_empty) begin
                            err_set   = 1'b1;
                            state_nxt = ST_HALT;
                        end else begin
                            pop     = 1'b1;
                            pc_next = ras_dout;
                        end
                    end
                    OP_HALT: state_nxt = ST_HALT;
                    default: pc_next = pc_inc;
                endcase
            end
            ST_HALT: begin
                halted    = 1'b1;
                state_nxt = ST_HALT;
            end
            default: state_nxt = ST_FETCH;
        endcase

        // Reset overrides everything and drops any in-flight stack operation.
        if (!RST) begin
            pc_next   = pc_cur;
            fetch_req = 1'b0;
            halted    = 1'b0;
            load      = 1'b0;
            push      = 1'b0;
            pop       = 1'b0;
            err_set   = 1'b0;
        end
    end

endmodule
